shift_mix_stage: RTL and testbench
==================================

Name: shift_mix_stage

Overview:
- Registered AES encryption stage directly downstream of SubBytes. It applies ShiftRows, then MixColumns, to each 128-bit state it accepts.
- It tracks the round number internally and bypasses MixColumns on the final round (round NR).
- Output goes to the AddRoundKey stage.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so that in_ready comes from a register.

Parameters:
NR, 10, number of AES rounds (10/12/14 for AES-128/192/256); the round counter wraps after NR.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  in_data/in_first valid
in_ready  output  1  stage can accept a beat this cycle
in_data  input  128  SubBytes output state; byte 0 = in_data[127:120], column-major (byte k = row k%4, column k/4)
in_first  input  1  beat is round 1 of a new block; forces round counter to 1
out_valid  output  1  out_data/out_last valid
out_ready  input  1  downstream accepts this cycle
out_data  output  128  ShiftRows(+MixColumns) result, same byte order
out_last  output  1  beat was round NR (MixColumns bypassed)

Behaviour:
- Reset, synchronous on rst=1:
  - out_valid=0, out_data=0, out_last=0.
  - Skid buffer empty; in_ready=1 in the cycle after reset.
  - Round counter = 1.
  - Reset mid-operation drops all buffered beats with no output.
- Accept and transfer:
  - A beat is accepted when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- ShiftRows: row r rotated left by r bytes. New byte (r, c) = old byte (r, (c+r) mod 4).
- MixColumns: standard GF(2^8) matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2]. xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).
- Round tracking (processed at accept):
  - Beat round = in_first ? 1 : rnd.
  - If beat round == NR: MixColumns bypassed and out_last=1 for that beat; rnd <= 1.
  - Otherwise: rnd <= beat round + 1.
  - in_first on a beat whose counter already reads 1 has no additional effect.
- Datapath latency: the result is computed combinationally at accept and registered, so latency is 1 cycle (accept in cycle N -> out_valid in cycle N+1) when the output register is free or draining.
- Buffering:
  - Output register (1 entry) plus skid register (1 entry).
  - If the output register is empty, or out_ready=1 that cycle, an accepted beat loads the output register.
  - Otherwise the accepted beat loads the skid register.
  - When the output transfers and the skid is full, the skid moves into the output register; out_valid stays 1.
- in_ready = !skid_full, registered. It drops the cycle after the skid fills and rises the cycle after the skid drains.
- Simultaneous accept and transfer with both registers occupied cannot happen, because in_ready=0.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- out_data, out_last: hold stable while out_valid && !out_ready.

Optional Feature:
- Macro SHIFT_MIX_STATS_EN.
- Defined:
  - Adds output beat_count [31:0]: increments per output transfer.
  - Adds output stall_count [31:0]: increments each cycle with out_valid && !out_ready.
  - Both counters reset to 0 and wrap modulo 2^32.
- Not defined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Round 1 MixColumns: after reset, one beat in_first=1, in_data=128'hD42711AEE0BF98F1B8B45DE51E415230, out_ready=1 -> next cycle out_valid=1, out_data=128'h046681E5E0CB199A48F8D37A2806264C, out_last=0.
- Final round bypass:
  - Stimulus: 9 beats starting with in_first=1, then 10th beat in_data=128'hE9098972CB31075F3D327D94AF2E2CB5.
  - Response: 10th output = 128'hE9317DB5CB322C723D2E895FAF090794 with out_last=1.
  - Next beat (in_first=0) is processed as round 1 (out_last=0).
- Backpressure:
  - Stimulus: out_ready=0, 3 consecutive in_valid beats.
  - Response: first two accepted; in_ready=0 from the cycle after the 2nd accept; 3rd held.
  - Then out_ready=1: outputs emerge in order with no loss, and out_data stays stable during the stall.
- Resync: in_first=1 on a beat while rnd=5 -> that beat round 1 (MixColumns applied); count resumes at 2.
- Reset mid-stream:
  - Stimulus: rst=1 with both entries full.
  - Response: next cycle out_valid=0, out_data=0, in_ready=1; next in_data=D427... beat yields 0466... as round 1.
- With SHIFT_MIX_STATS_EN: 4 transfers and 3 stall cycles -> beat_count=4, stall_count=3; reset clears both.

Source files
------------

// File: rtl/shift_mix_stage_if.sv
// Handshake bundle between SubBytes, the ShiftRows/MixColumns stage and AddRoundKey.
// The slave view is the stage itself; the master view is the surrounding pipeline.
interface shift_mix_stage_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_first;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;

  modport slave (
    input  in_valid, in_data, in_first, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_first, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/shift_mix_stage.sv
// AES ShiftRows + MixColumns stage with round tracking and a 2-entry skid buffer.
// Optional SHIFT_MIX_STATS_EN adds beat_count/stall_count statistics outputs.
module shift_mix_stage #(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_mix_stage_if.slave     bus
`ifdef SHIFT_MIX_STATS_EN
  ,
  output logic [31:0]          beat_count,
  output logic [31:0]          stall_count
`endif
);

  localparam int RW = $clog2(NR + 1);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Byte k lives at bits [127-8k -: 8]; row = k%4, column = k/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  logic [RW-1:0] rnd;
  logic [RW-1:0] beat_rnd;
  logic          beat_last;
  logic [127:0]  shifted;
  logic [127:0]  result;
  logic          accept;
  logic          xfer;

  logic          out_valid_q;
  logic [127:0]  out_data_q;
  logic          out_last_q;
  logic          skid_full;
  logic [127:0]  skid_data;
  logic          skid_last;
  logic          in_ready_q;

  assign accept    = bus.in_valid && in_ready_q;
  assign xfer      = out_valid_q && bus.out_ready;
  assign beat_rnd  = bus.in_first ? RW'(1) : rnd;
  assign beat_last = (beat_rnd == RW'(NR));
  assign shifted   = shift_rows(bus.in_data);
  assign result    = beat_last ? shifted : mix_columns(shifted);

  // The skid can only be full while in_ready is low, so a skid-to-output
  // move never coincides with an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_full   <= 1'b0;
      skid_data   <= '0;
      skid_last   <= 1'b0;
      in_ready_q  <= 1'b1;
      rnd         <= RW'(1);
    end else begin
      if (accept) begin
        rnd <= beat_last ? RW'(1) : beat_rnd + RW'(1);
      end
      if (xfer && skid_full) begin
        out_data_q <= skid_data;
        out_last_q <= skid_last;
        skid_full  <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (accept && (!out_valid_q || xfer)) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result;
        out_last_q  <= beat_last;
      end else if (accept) begin
        skid_full  <= 1'b1;
        skid_data  <= result;
        skid_last  <= beat_last;
        in_ready_q <= 1'b0;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

`ifdef SHIFT_MIX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count  <= '0;
      stall_count <= '0;
    end else begin
      if (xfer) beat_count <= beat_count + 32'd1;
      if (out_valid_q && !bus.out_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_mix_stage.sv
// Self-checking bench for shift_mix_stage: a table of rounds with hand-computed
// AES results, plus backpressure, mid-stream reset and optional statistics sequences.
module tb_shift_mix_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_mix_stage_if bus();

`ifdef SHIFT_MIX_STATS_EN
  logic [31:0] beat_count;
  logic [31:0] stall_count;
`endif

  shift_mix_stage #(.NR(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef SHIFT_MIX_STATS_EN
    ,
    .beat_count  (beat_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         first;
    logic [127:0] data;
    logic [127:0] exp_data;
    logic         exp_last;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  int vec_count  = 0;
  int miss_count = 0;

  localparam logic [127:0] R1_IN   = 128'hD42711AEE0BF98F1B8B45DE51E415230;
  localparam logic [127:0] R1_OUT  = 128'h046681E5E0CB199A48F8D37A2806264C;
  localparam logic [127:0] FIN_IN  = 128'hE9098972CB31075F3D327D94AF2E2CB5;
  localparam logic [127:0] FIN_OUT = 128'hE9317DB5CB322C723D2E895FAF090794;
  localparam logic [127:0] DB_IN   = {4{32'hDB135345}};
  localparam logic [127:0] DB_OUT  = {4{32'h8E4DA1BC}};
  localparam logic [127:0] F2_IN   = {4{32'hF20A225C}};
  localparam logic [127:0] F2_OUT  = {4{32'h9FDC589D}};

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic first, input logic [127:0] data);
    int waits;
    waits = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_first = first;
    bus.in_data  = data;
    while (!bus.in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) begin
      vec_count++;
      miss_count++;
      $display("[TB] FAIL accept_timeout: in_ready %b, expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    // Rounds 1..10 of one block, a wrap to round 1, then a resync at rnd=5.
    vecs[0]  = '{1'b1, R1_IN, R1_OUT, 1'b0};
    vecs[1]  = '{1'b0, DB_IN, DB_OUT, 1'b0};
    vecs[2]  = '{1'b0, F2_IN, F2_OUT, 1'b0};
    vecs[3]  = '{1'b0, {4{32'h01010101}}, {4{32'h01010101}}, 1'b0};
    vecs[4]  = '{1'b0, {4{32'hC6C6C6C6}}, {4{32'hC6C6C6C6}}, 1'b0};
    vecs[5]  = '{1'b0, {4{32'hD4D4D4D5}}, {4{32'hD5D5D7D6}}, 1'b0};
    vecs[6]  = '{1'b0, {4{32'h2D26314C}}, {4{32'h4D7EBDF8}}, 1'b0};
    vecs[7]  = '{1'b0, {4{32'h80000000}}, {4{32'h1B80809B}}, 1'b0};
    vecs[8]  = '{1'b0, 128'h0, 128'h0, 1'b0};
    vecs[9]  = '{1'b0, FIN_IN, FIN_OUT, 1'b1};
    vecs[10] = '{1'b0, R1_IN, R1_OUT, 1'b0};
    for (int i = 11; i < 14; i++) vecs[i] = '{1'b0, DB_IN, DB_OUT, 1'b0};
    vecs[14] = '{1'b1, DB_IN, DB_OUT, 1'b0};
    for (int i = 15; i < 23; i++) vecs[i] = '{1'b0, DB_IN, DB_OUT, 1'b0};
    vecs[23] = '{1'b0, FIN_IN, FIN_OUT, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkFlag("reset_out_valid", bus.out_valid, 1'b0);
    checkOutput("reset_out_data", bus.out_data, 128'h0);
    checkFlag("reset_out_last", bus.out_last, 1'b0);
    checkFlag("reset_in_ready", bus.in_ready, 1'b1);

    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].first, vecs[i].data);
      @(negedge clk);
      checkFlag($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
      checkOutput($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp_data);
      checkFlag($sformatf("vec%0d_last", i), bus.out_last, vecs[i].exp_last);
    end
    @(negedge clk);
    checkFlag("drain_out_valid", bus.out_valid, 1'b0);

    // Backpressure: A to output, B to skid, C held until the skid drains.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_first  = 1'b1;
    bus.in_data   = R1_IN;
    @(negedge clk);
    checkFlag("bp_ready_after_1", bus.in_ready, 1'b1);
    checkFlag("bp_valid_a", bus.out_valid, 1'b1);
    bus.in_first = 1'b0;
    bus.in_data  = DB_IN;
    @(negedge clk);
    checkFlag("bp_ready_drop", bus.in_ready, 1'b0);
    checkOutput("bp_hold_a", bus.out_data, R1_OUT);
    bus.in_data = F2_IN;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkFlag($sformatf("bp_ready_low%0d", i), bus.in_ready, 1'b0);
      checkOutput($sformatf("bp_stable%0d", i), bus.out_data, R1_OUT);
      checkFlag($sformatf("bp_valid_hold%0d", i), bus.out_valid, 1'b1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_out_b", bus.out_data, DB_OUT);
    checkFlag("bp_valid_b", bus.out_valid, 1'b1);
    checkFlag("bp_ready_rise", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("bp_out_c", bus.out_data, F2_OUT);
    checkFlag("bp_valid_c", bus.out_valid, 1'b1);
    @(negedge clk);
    checkFlag("bp_drained", bus.out_valid, 1'b0);

    // Reset with both entries occupied; the round counter must also return to 1.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_first  = 1'b1;
    bus.in_data   = F2_IN;
    @(negedge clk);
    bus.in_first = 1'b0;
    bus.in_data  = DB_IN;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkFlag("mid_full_ready", bus.in_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkFlag("mid_rst_valid", bus.out_valid, 1'b0);
    checkOutput("mid_rst_data", bus.out_data, 128'h0);
    checkFlag("mid_rst_ready", bus.in_ready, 1'b1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, R1_IN);
    @(negedge clk);
    checkFlag("mid_post_valid", bus.out_valid, 1'b1);
    checkOutput("mid_post_data", bus.out_data, R1_OUT);
    checkFlag("mid_post_last", bus.out_last, 1'b0);
    @(negedge clk);

`ifdef SHIFT_MIX_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("stats_rst_beats", 128'(beat_count), 128'h0);
    checkOutput("stats_rst_stalls", 128'(stall_count), 128'h0);
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, R1_IN);
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, DB_IN);
    @(posedge clk);
    #1;
    checkOutput("stats_beats", 128'(beat_count), 128'd4);
    checkOutput("stats_stalls", 128'(stall_count), 128'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("stats_clr_beats", 128'(beat_count), 128'h0);
    checkOutput("stats_clr_stalls", 128'(stall_count), 128'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
